// File: rtl/pulse_period_monitor.sv
//------------------------------------------------------------------------------
// pulse_period_monitor: learns the spacing of single-cycle event strobes,
// locks onto a stable period and flags missed/early pulses with a sticky error.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pulse_period_monitor #(
  parameter int CNT_W  = 4,
  parameter int LOCK_N = 2,
  parameter int EVC_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] period_o,
  output logic             err_o,
  output logic [EVC_W-1:0] ev_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] GAP_MAX  = '1;
  localparam logic [CNT_W-1:0] GAP_ONE  = CNT_W'(1);
  localparam logic [EVC_W-1:0] EVC_MAX  = '1;
  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cand_q, cand_d;
  logic [3:0]       match_q, match_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             err_q, err_d;
  logic [EVC_W-1:0] ev_cnt_q, ev_cnt_d;
  logic             err_set;
  logic [3:0]       match_inc;

  assign match_inc = match_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    locked_d = locked_q;
    period_d = period_q;
    err_set  = 1'b0;

    // An event always starts a fresh interval, including the first one out of IDLE.
    if (ev_i) begin
      gap_d = GAP_ONE;
    end else if (state_q == S_IDLE) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GAP_ONE;
    end else begin
      gap_d = gap_q;
    end

    case (state_q)
      S_IDLE: begin
        if (ev_i) begin
          state_d = S_MEASURE;
          match_d = '0;
        end
      end
      S_MEASURE: begin
        if (ev_i) begin
          if (gap_q == GAP_MAX) begin
            match_d = '0;
          end else if (match_q == 4'd0) begin
            cand_d  = gap_q;
            match_d = 4'd1;
          end else if (gap_q == cand_q) begin
            match_d = match_inc;
            if (match_inc == LOCK_CNT) begin
              state_d  = S_LOCKED;
              period_d = cand_q;
              locked_d = 1'b1;
            end
          end else begin
            cand_d  = gap_q;
            match_d = 4'd1;
          end
        end
      end
      S_LOCKED: begin
        // Early pulse restarts gap via the event path above; a missed one lets it run.
        if ((ev_i && (gap_q != period_q)) || (!ev_i && (gap_q == period_q))) begin
          err_set  = 1'b1;
          locked_d = 1'b0;
          period_d = '0;
          state_d  = S_MEASURE;
          match_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    err_d    = err_set | (err_q & ~clr_i);
    ev_cnt_d = (ev_i && (ev_cnt_q != EVC_MAX)) ? ev_cnt_q + EVC_W'(1) : ev_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      cand_q   <= '0;
      match_q  <= '0;
      locked_q <= 1'b0;
      period_q <= '0;
      err_q    <= 1'b0;
      ev_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      period_q <= period_d;
      err_q    <= err_d;
      ev_cnt_q <= ev_cnt_d;
    end
  end

  assign locked_o = locked_q;
  assign period_o = period_q;
  assign err_o    = err_q;
  assign ev_cnt_o = ev_cnt_q;
  assign state_o  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_period_monitor.sv
//------------------------------------------------------------------------------
// tb_pulse_period_monitor: directed checks of locking, missed/early errors,
// timeout, reset and event-count saturation.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pulse_period_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ev_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       locked_o;
  logic [3:0] period_o;
  logic       err_o;
  logic [7:0] ev_cnt_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  pulse_period_monitor #(
    .CNT_W  (4),
    .LOCK_N (2),
    .EVC_W  (8)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .ev_i     (ev_i),
    .clr_i    (clr_i),
    .locked_o (locked_o),
    .period_o (period_o),
    .err_o    (err_o),
    .ev_cnt_o (ev_cnt_o),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic e, input logic c);
    ev_i  = e;
    clr_i = c;
    @(posedge clk);
    #1;
    ev_i  = 1'b0;
    clr_i = 1'b0;
  endtask

  // Event arriving n cycles after the previous one.
  task automatic gap_ev(input int n);
    repeat (n - 1) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
  endtask

  int bad;
  int nonuni [5] = '{3, 5, 3, 5, 3};

  initial begin
    // Reset state
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("rst_locked", locked_o, 0);
    check("rst_period", period_o, 0);
    check("rst_err", err_o, 0);
    check("rst_evcnt", ev_cnt_o, 0);
    check("rst_state", state_o, 0);
    reset = 1'b1;

    // Reference cadence: 2-bit counter decode pulses every 4 cycles
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("ref_ev1_state", state_o, 1);
    check("ref_ev1_evcnt", ev_cnt_o, 1);
    gap_ev(4);
    check("ref_ev2_locked", locked_o, 0);
    gap_ev(4);
    check("ref_ev3_locked", locked_o, 1);
    check("ref_ev3_period", period_o, 4);
    check("ref_ev3_state", state_o, 2);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      gap_ev(4);
      if (err_o !== 1'b0 || locked_o !== 1'b1) bad++;
    end
    check("ref_stable_bad", bad, 0);
    check("ref_evcnt", ev_cnt_o, 28);

    // Missed pulse
    repeat (3) cyc(1'b0, 1'b0);
    check("miss_pre_locked", locked_o, 1);
    check("miss_pre_err", err_o, 0);
    cyc(1'b0, 1'b0);
    check("miss_err", err_o, 1);
    check("miss_locked", locked_o, 0);
    check("miss_period", period_o, 0);
    check("miss_state", state_o, 1);
    gap_ev(4);
    check("miss_ev_a_locked", locked_o, 0);
    gap_ev(4);
    check("miss_ev_b_locked", locked_o, 0);
    gap_ev(4);
    check("relock_locked", locked_o, 1);
    check("relock_period", period_o, 4);
    check("relock_err_sticky", err_o, 1);
    cyc(1'b0, 1'b1);
    check("clr_err", err_o, 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("post_clr_locked", locked_o, 1);
    check("post_clr_err", err_o, 0);

    // Early pulse two cycles after an event
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("early_err", err_o, 1);
    check("early_locked", locked_o, 0);
    check("early_period", period_o, 0);
    check("early_state", state_o, 1);
    gap_ev(4);
    check("early_ev_a_locked", locked_o, 0);
    gap_ev(4);
    check("early_relock", locked_o, 1);
    check("early_relock_period", period_o, 4);
    cyc(1'b0, 1'b1);
    check("early_clr", err_o, 0);
    cyc(1'b1, 1'b1);
    check("clr_vs_set_err", err_o, 1);
    check("clr_vs_set_locked", locked_o, 0);
    cyc(1'b0, 1'b1);
    check("clr_after_set", err_o, 0);

    // Non-uniform intervals never lock, then 3,3 locks
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    check("nu_rst_state", state_o, 0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      gap_ev(nonuni[i]);
      check($sformatf("nu_int%0d_locked", i), locked_o, 0);
    end
    gap_ev(3);
    check("nu_lock", locked_o, 1);
    check("nu_period", period_o, 3);

    // Reset while locked; the event on the reset edge is ignored
    reset = 1'b0;
    cyc(1'b1, 1'b0);
    check("rstl_locked", locked_o, 0);
    check("rstl_period", period_o, 0);
    check("rstl_err", err_o, 0);
    check("rstl_evcnt", ev_cnt_o, 0);
    check("rstl_state", state_o, 0);
    reset = 1'b1;

    // Timeout: 20-cycle intervals exceed the measurable range
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      gap_ev(20);
      check($sformatf("to%0d_locked", i), locked_o, 0);
      check($sformatf("to%0d_err", i), err_o, 0);
    end
    check("to_state", state_o, 1);

    // Event count saturation with period-1 events
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    repeat (254) cyc(1'b1, 1'b0);
    check("sat_254", ev_cnt_o, 254);
    repeat (46) cyc(1'b1, 1'b0);
    check("sat_255", ev_cnt_o, 255);
    check("p1_locked", locked_o, 1);
    check("p1_period", period_o, 1);
    check("p1_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_period_monitor.md
# pulse_period_monitor

Downstream checker for the single-cycle decode strobes produced by the small free-running counter test blocks, for example the 2-bit counter whose output pulses when the count equals 2. It learns the spacing between event pulses and locks onto a stable period. Once locked, it flags any missed or early pulse with a sticky error, then relearns. It also keeps a saturating event count, so formal properties and simulation can check the upstream counter's cadence.

## Interface
- CNT_W, 4: interval counter width; largest measurable interval is 2^CNT_W-2.
- LOCK_N, 2: consecutive equal intervals required to lock; legal range 2..15.
- EVC_W, 8: event counter width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; clock clk.
- ev  in  1  event strobe from the upstream stage; every cycle sampled high is one event.
- clr  in  1  clears the sticky error.
- locked  out  1  period learned and being tracked.
- period  out  CNT_W  locked interval in cycles; 0 when not locked.
- err  out  1  sticky deviation flag.
- ev_cnt  out  EVC_W  saturating count of events.
- state  out  2  FSM state for debug: IDLE=0, MEASURE=1, LOCKED=2.

## Operation
- gap register (CNT_W bits) measures cycles since the last event:
  - In IDLE, gap holds 0.
  - Otherwise, on an edge sampling ev=1, gap<=1.
  - Otherwise gap<=gap+1, saturating at MAX=2^CNT_W-1.
- Interval measured at an event = value of gap on that edge. gap==MAX means timeout and an invalid interval.
- Internal registers: cand (CNT_W, candidate interval) and match (4 bits, count of consecutive equal intervals).
- IDLE:
  - ev=1 -> MEASURE, match<=0.
- MEASURE, on ev=1:
  - gap==MAX -> match<=0.
  - match==0 -> cand<=gap, match<=1.
  - gap==cand -> match<=match+1; if match+1==LOCK_N -> LOCKED, period<=cand, locked<=1.
  - gap!=cand -> cand<=gap, match<=1.
- LOCKED:
  - ev=1 and gap==period -> stay.
  - ev=1 and gap!=period (early pulse) -> error.
  - ev=0 and gap==period (missed pulse) -> error.
- Error action, all on the same edge:
  - err<=1, locked<=0, period<=0, state<=MEASURE, match<=0.
  - An early event also restarts gap at 1 and counts as the first event of the new measurement.
  - For a missed pulse, gap keeps counting.
- err clears only on clr=1. If clr and a new error occur on the same edge, err stays 1 (set wins).
- ev_cnt increments on every edge sampling ev=1, in any state, and saturates at 2^EVC_W-1.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values:
  - Outputs: locked=0, period=0, err=0, ev_cnt=0, state=IDLE.
  - Internal: gap=0, cand=0, match=0.
- Reset is synchronous. Asserting it mid-operation, including while LOCKED, forces all reset values on the next edge.
- Events sampled on the same edge as an active reset are ignored.
- Lock latency: locked rises on the edge sampling the (LOCK_N+1)-th event after IDLE. Default: the 3rd event.
- Error latency:
  - Missed pulse: err rises on the edge where gap==period and ev=0, i.e. period cycles after the last good event.
  - Early pulse: err rises on the edge sampling the early event.
- Interval range is 1..MAX-1. Interval 1 means ev is high on consecutive cycles, which is a legal period of 1.
- Timed-out intervals never contribute to a match.

## Test plan
- Reference cadence: feed z1 of the 2-bit upstream counter after reset release (events every 4 cycles).
  - Expect locked=1, period=4 on the edge of the 3rd event.
  - Expect err=0 for 100 cycles.
- Missed pulse: lock at 4, then suppress one event.
  - Expect err=1, locked=0, period=0 exactly 4 cycles after the last event.
  - Expect relock (period=4) on the 2nd following matching interval; err stays 1 until clr.
- Early pulse: while locked at 4, inject an extra ev 2 cycles after an event.
  - Expect err=1 on that edge, with gap restarting from it.
  - clr asserted together with a second error keeps err=1.
- Non-uniform intervals 3,5,3,5 -> locked never asserts. Then intervals 3,3 -> locked=1, period=3.
- Timeout (CNT_W=4): events 20 cycles apart -> locked stays 0 and err stays 0.
- Reset and saturation:
  - Reset asserted while locked -> all outputs 0 on the next edge.
  - 300 single-cycle events -> ev_cnt=255.
